addr_reg_bank: RTL and testbench

Parametrised bank of address-bus registers for the relay computer model; generalises the single bus-attached address register into NREGS registers of WIDTH bits sharing one address bus, and adds a sequenced register-to-register move and an increment path (PC/XY-style "+1 and write back"). Commands arrive through a valid/ready handshake and each one runs a fixed three-phase relay-style sequence: select, latch, write-back. The block sits between the sequencer/control unit and the 16-bit address bus, replacing the per-register bus wrappers.

---
 rtl/addr_reg_pkg.sv | 25 ++
 rtl/addr_incrementer.sv | 12 +
 rtl/addr_reg_bank.sv | 158 +++++++++++++++
 tb/tb_addr_reg_bank.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_reg_pkg.sv
// Shared types for the address-register bank: command opcodes, sequencer states
// and the default bus width.
package addr_reg_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_DRIVE = 2'd1,
        OP_MOVE  = 2'd2,
        OP_INC   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // MOVE and INC are the only commands that write a second register index.
    function automatic logic op_uses_dst(input op_e op);
        return (op == OP_MOVE) || (op == OP_INC);
    endfunction

endpackage

// File: rtl/addr_incrementer.sv
// Combinational +1 with carry-out, used for PC/XY-style increment-and-write-back.
module addr_incrementer #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    assign {carry_out, sum} = {1'b0, value} + {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/addr_reg_bank.sv
// Bank of NREGS bus-attached address registers with a select/latch/write-back sequencer.
// Define ADDR_REG_INC_EN to build the increment path; otherwise INC is rejected.
module addr_reg_bank
    import addr_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NREGS = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_src,
    input  logic [IDX_W-1:0] cmd_dst,
    input  logic [WIDTH-1:0] addr_in,
    output logic [WIDTH-1:0] addr_out,
    output logic             addr_oe,
    output logic             done,
    output logic             err,
    output logic             carry
);

`ifdef ADDR_REG_INC_EN
    localparam bit INC_EN = 1'b1;
`else
    localparam bit INC_EN = 1'b0;
`endif

    state_e           state;
    op_e              op_q;
    logic [IDX_W-1:0] src_q;
    logic [IDX_W-1:0] dst_q;
    logic             bad_q;
    logic [WIDTH-1:0] temp;
    logic [WIDTH-1:0] next_temp;
    logic [WIDTH-1:0] regs [NREGS];

    op_e              cmd_op_e;
    logic             cmd_bad;
    logic             cmd_drives;
    logic [WIDTH-1:0] cmd_val;
    logic [WIDTH-1:0] src_val;

    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return 32'(idx) < 32'(NREGS);
    endfunction

    assign cmd_op_e   = op_e'(cmd_op);
    assign cmd_bad    = !idx_ok(cmd_src)
                      || (op_uses_dst(cmd_op_e) && !idx_ok(cmd_dst))
                      || ((cmd_op_e == OP_INC) && !INC_EN);
    assign cmd_drives = !cmd_bad && (cmd_op_e != OP_LOAD);
    assign cmd_val    = regs[cmd_src];
    assign src_val    = regs[src_q];
    assign cmd_ready  = (state == ST_IDLE);

`ifdef ADDR_REG_INC_EN
    logic [WIDTH-1:0] inc_sum;
    logic             inc_co;
    logic             carry_q;

    addr_incrementer #(
        .WIDTH (WIDTH)
    ) u_inc (
        .value     (src_val),
        .sum       (inc_sum),
        .carry_out (inc_co)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            carry_q <= 1'b0;
        end else if (state == ST_SEL && op_q == OP_INC && !bad_q) begin
            carry_q <= inc_co;
        end
    end

    assign carry = carry_q;
`else
    assign carry = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_temp = src_val;
        case (op_q)
            OP_LOAD: next_temp = addr_in;
`ifdef ADDR_REG_INC_EN
            OP_INC:  next_temp = inc_sum;
`endif
            default: ;
        endcase
    end

    // Bus drive value is captured at accept: the array only changes at WB->IDLE,
    // so the registered copy is stable for the whole SEL cycle.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            op_q     <= OP_LOAD;
            src_q    <= '0;
            dst_q    <= '0;
            bad_q    <= 1'b0;
            temp     <= '0;
            addr_out <= '0;
            addr_oe  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q     <= cmd_op_e;
                        src_q    <= cmd_src;
                        dst_q    <= cmd_dst;
                        bad_q    <= cmd_bad;
                        addr_oe  <= cmd_drives;
                        addr_out <= cmd_drives ? cmd_val : '0;
                        state    <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    temp     <= next_temp;
                    addr_oe  <= 1'b0;
                    addr_out <= '0;
                    done     <= 1'b1;
                    err      <= bad_q;
                    state    <= ST_WB;
                end
                ST_WB: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the register array is reset explicitly; a mid-command reset must leave every register at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == ST_WB && !bad_q) begin
            case (op_q)
                OP_LOAD:        regs[src_q] <= temp;
                OP_MOVE, OP_INC: regs[dst_q] <= temp;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addr_reg_bank.sv
// Self-checking bench: a 4-register and a 3-register bank share one command stream and are
// compared against a behavioural model; directed table, hold/reset sequences, then random traffic.
module tb_addr_reg_bank;

`ifdef ADDR_REG_INC_EN
    localparam bit inc_en = 1'b1;
`else
    localparam bit inc_en = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_src;
    logic [1:0]  cmd_dst;
    logic [15:0] addr_in;

    logic        ready4, oe4, done4, err4, carry4;
    logic [15:0] out4;
    logic        ready3, oe3, done3, err3, carry3;
    logic [15:0] out3;

    int tests = 0;
    int fails = 0;

    // Reference state: row 0 models the 4-register bank, row 1 the 3-register bank.
    logic [15:0] m_regs  [2][4];
    logic        m_carry [2];

    always #5 clk = ~clk;

    addr_reg_bank #(.WIDTH(16), .NREGS(4), .IDX_W(2)) dut4 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(ready4),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .addr_in(addr_in),
        .addr_out(out4), .addr_oe(oe4), .done(done4), .err(err4), .carry(carry4)
    );

    addr_reg_bank #(.WIDTH(16), .NREGS(3), .IDX_W(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(ready3),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .addr_in(addr_in),
        .addr_out(out3), .addr_oe(oe3), .done(done3), .err(err3), .carry(carry3)
    );

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  src;
        logic [1:0]  dst;
        logic [15:0] ain;
        logic        exp_oe;
        logic [15:0] exp_out;
        logic        exp_err;
        logic        exp_carry;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] obs(input int d);
        if (d == 0) return {ready4, oe4, done4, err4, carry4, out4};
        return {ready3, oe3, done3, err3, carry3, out3};
    endfunction

    function automatic int nregs(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic bit m_bad(input int d, input logic [1:0] op, input logic [1:0] src,
                                 input logic [1:0] dst);
        return (int'(src) >= nregs(d))
            || ((op == 2'd2 || op == 2'd3) && int'(dst) >= nregs(d))
            || (op == 2'd3 && !inc_en);
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_carry[d] = 1'b0;
            for (int i = 0; i < 4; i++) m_regs[d][i] = 16'h0000;
        end
    endtask

    task automatic check_obs(input int d, input string tag, input logic ready, input logic oe,
                             input logic [15:0] out, input logic dn, input logic er,
                             input logic cy);
        logic [20:0] o;
        o = obs(d);
        check($sformatf("d%0d_%s_ready", d, tag), o[20], ready);
        check($sformatf("d%0d_%s_oe", d, tag), o[19], oe);
        check($sformatf("d%0d_%s_out", d, tag), o[15:0], out);
        check($sformatf("d%0d_%s_done", d, tag), o[18], dn);
        check($sformatf("d%0d_%s_err", d, tag), o[17], er);
        check($sformatf("d%0d_%s_carry", d, tag), o[16], cy);
    endtask

    // Runs one command; entered and left #1 after a rising edge with both banks idle.
    task automatic do_cmd(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                          input logic [15:0] ain, input bit hold,
                          output logic sel_oe, output logic [15:0] sel_out,
                          output logic wb_err, output logic wb_carry);
        bit          bad [2];
        logic [15:0] val;
        for (int d = 0; d < 2; d++) bad[d] = m_bad(d, op, src, dst);
        check("d4_idle_ready", ready4, 1'b1);
        check("d3_idle_ready", ready3, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        addr_in   = ain;
        @(posedge clk); #1;
        cmd_valid = hold;
        cmd_op    = 2'($urandom);
        cmd_src   = 2'($urandom);
        cmd_dst   = 2'($urandom);
        for (int d = 0; d < 2; d++) begin
            if (!bad[d] && op != 2'd0)
                check_obs(d, "sel", 1'b0, 1'b1, m_regs[d][src], 1'b0, 1'b0, m_carry[d]);
            else
                check_obs(d, "sel", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, m_carry[d]);
        end
        sel_oe  = oe4;
        sel_out = out4;
        @(posedge clk); #1;
        addr_in = 16'($urandom);
        for (int d = 0; d < 2; d++) begin
            if (!bad[d]) begin
                val = m_regs[d][src];
                case (op)
                    2'd0: m_regs[d][src] = ain;
                    2'd2: m_regs[d][dst] = val;
                    2'd3: begin
                        m_carry[d]       = (val == 16'hFFFF);
                        m_regs[d][dst]   = val + 16'd1;
                    end
                    default: ;
                endcase
            end
            check_obs(d, "wb", 1'b0, 1'b0, 16'h0000, 1'b1, bad[d], m_carry[d]);
        end
        wb_err   = err4;
        wb_carry = carry4;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int d = 0; d < 2; d++)
            check_obs(d, "post", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, m_carry[d]);
    endtask

    initial begin
        logic        s_oe, w_err, w_cy;
        logic [15:0] s_out;
        logic [1:0]  rop;
        logic [15:0] rain;

        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_src   = 2'd0;
        cmd_dst   = 2'd0;
        addr_in   = 16'h0000;
        reset_n   = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++)
            check_obs(d, "reset", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed table: expectations for the 4-register bank written out by hand.
        vecs.push_back('{2'd0, 2'd1, 2'd0, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 2'd1, 2'd0, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0});
        vecs.push_back('{2'd0, 2'd0, 2'd0, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{2'd3, 2'd0, 2'd0, 16'h0000, inc_en, inc_en ? 16'hFFFF : 16'h0000,
                         !inc_en, inc_en});
        vecs.push_back('{2'd1, 2'd0, 2'd0, 16'h0000, 1'b1, inc_en ? 16'h0000 : 16'hFFFF,
                         1'b0, inc_en});
        vecs.push_back('{2'd3, 2'd0, 2'd0, 16'h0000, inc_en, 16'h0000, !inc_en, 1'b0});
        vecs.push_back('{2'd1, 2'd0, 2'd0, 16'h0000, 1'b1, inc_en ? 16'h0001 : 16'hFFFF,
                         1'b0, 1'b0});
        vecs.push_back('{2'd0, 2'd2, 2'd0, 16'h00A5, 1'b0, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{2'd2, 2'd2, 2'd3, 16'h0000, 1'b1, 16'h00A5, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 2'd3, 2'd0, 16'h0000, 1'b1, 16'h00A5, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 2'd2, 2'd0, 16'h0000, 1'b1, 16'h00A5, 1'b0, 1'b0});
        vecs.push_back('{2'd2, 2'd3, 2'd3, 16'h0000, 1'b1, 16'h00A5, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 2'd3, 2'd0, 16'h0000, 1'b1, 16'h00A5, 1'b0, 1'b0});
        vecs.push_back('{2'd2, 2'd3, 2'd0, 16'h0000, 1'b1, 16'h00A5, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 2'd0, 2'd0, 16'h0000, 1'b1, 16'h00A5, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 2'd1, 2'd0, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            do_cmd(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].ain, 1'b0,
                   s_oe, s_out, w_err, w_cy);
            check($sformatf("vec%0d_oe", i), s_oe, vecs[i].exp_oe);
            check($sformatf("vec%0d_out", i), s_out, vecs[i].exp_out);
            check($sformatf("vec%0d_err", i), w_err, vecs[i].exp_err);
            check($sformatf("vec%0d_carry", i), w_cy, vecs[i].exp_carry);
        end

        // cmd_valid held through SEL/WB must not start a second increment.
        do_cmd(2'd0, 2'd1, 2'd0, 16'h0010, 1'b0, s_oe, s_out, w_err, w_cy);
        do_cmd(2'd3, 2'd1, 2'd1, 16'h0000, 1'b1, s_oe, s_out, w_err, w_cy);
        do_cmd(2'd1, 2'd1, 2'd0, 16'h0000, 1'b0, s_oe, s_out, w_err, w_cy);
        check("hold_single_inc", s_out, inc_en ? 16'h0011 : 16'h0010);

        // Reset asserted in the SEL cycle of an INC discards it and clears everything.
        do_cmd(2'd0, 2'd1, 2'd0, 16'h0010, 1'b0, s_oe, s_out, w_err, w_cy);
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        cmd_src   = 2'd1;
        cmd_dst   = 2'd1;
        @(posedge clk); #1;
        check("rst_sel_oe", oe4, inc_en);
        check("rst_sel_out", out4, inc_en ? 16'h0010 : 16'h0000);
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++)
            check_obs(d, "midrst", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        m_reset();
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++)
            check_obs(d, "release", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        do_cmd(2'd1, 2'd1, 2'd0, 16'h0000, 1'b0, s_oe, s_out, w_err, w_cy);
        check("rst_reg1_zero", s_out, 16'h0000);

        // Random traffic, biased towards all-ones loads so INC wraps regularly.
        for (int i = 0; i < 200; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rain = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            do_cmd(rop, 2'($urandom), 2'($urandom), rain, bit'($urandom_range(0, 1)),
                   s_oe, s_out, w_err, w_cy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
